// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_magnitude_comparator_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Result triple is ordered {Gre, Les, Equ}
    typedef logic [2:0] res_t;
    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_LT   = 3'b010;
    localparam res_t RES_EQ   = 3'b001;

endpackage

// File: rtl/serial_magnitude_comparator_nibble_cmp_slice.sv
// Combinational 4-bit compare; signed_top treats the nibble as the sign-carrying top nibble.
module nibble_cmp_slice
    import serial_magnitude_comparator_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                signed_top,
    output logic                gt,
    output logic                lt,
    output logic                eq
);

    logic [NIBBLE_W-1:0] a_ob;
    logic [NIBBLE_W-1:0] b_ob;

    // Flipping the sign bit maps two's complement onto offset binary, so an unsigned compare works
    assign a_ob = {a[NIBBLE_W-1] ^ signed_top, a[NIBBLE_W-2:0]};
    assign b_ob = {b[NIBBLE_W-1] ^ signed_top, b[NIBBLE_W-2:0]};

    assign gt = a_ob > b_ob;
    assign lt = a_ob < b_ob;
    assign eq = a_ob == b_ob;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Nibble-serial wide-word magnitude comparator, MSB nibble first, with cascade inputs.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first decided nibble instead of walking all nibbles.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Signed,
    input  logic             CasG,
    input  logic             CasL,
    input  logic             CasE,
    output logic             Busy,
    output logic             Done,
    output logic             Gre,
    output logic             Les,
    output logic             Equ
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t state, state_nxt;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, b_q;
    logic             sgn_q;
    logic [2:0]       cas_q;
    logic [IDX_W-1:0] idx, idx_nxt;
    res_t             sticky_q, res_q;
    logic             done_q;

    logic load, finish;
    logic gt, lt, eq;
    res_t slice_res, eff_res, cas_res, fin_res;

    nibble_cmp_slice u_slice (
        .a          (a_q[idx]),
        .b          (b_q[idx]),
        .signed_top (sgn_q && (idx == IDX_TOP)),
        .gt         (gt),
        .lt         (lt),
        .eq         (eq)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        finish    = 1'b0;
        slice_res = eq ? RES_NONE : (gt ? RES_GT : RES_LT);
        // Without early exit the first decision is sticky; later nibbles cannot override it
        eff_res   = (!EARLY_EXIT && sticky_q != RES_NONE) ? sticky_q : slice_res;
        cas_res   = cas_q[2] ? RES_GT : (cas_q[1] ? RES_LT : RES_EQ);
        fin_res   = (eff_res != RES_NONE) ? eff_res : cas_res;
        case (state)
            IDLE: begin
                if (Start) begin
                    load      = 1'b1;
                    idx_nxt   = IDX_TOP;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                if (idx == '0 || (EARLY_EXIT && eff_res != RES_NONE)) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            cas_q    <= 3'b000;
            sticky_q <= RES_NONE;
            res_q    <= RES_NONE;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            done_q <= finish;
            if (load) begin
                a_q      <= A;
                b_q      <= B;
                sgn_q    <= Signed;
                cas_q    <= {CasG, CasL, CasE};
                sticky_q <= RES_NONE;
            end else if (state == CMP && sticky_q == RES_NONE) begin
                sticky_q <= slice_res;
            end
            if (finish)
                res_q <= fin_res;
        end
    end

    assign Busy = (state == CMP);
    assign Done = done_q;
    assign {Gre, Les, Equ} = res_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator at WIDTH=16.
module tb_serial_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic        Signed = 1'b0, CasG = 1'b0, CasL = 1'b0, CasE = 1'b0;
    logic        Busy, Done, Gre, Les, Equ;

    typedef struct {
        logic [2:0] res;
        int         at;
    } exp_t;

    exp_t q[$];
    int   edges = 0;
    int   compared = 0;
    int   mismatched = 0;

    serial_magnitude_comparator #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .Signed(Signed),
        .CasG(CasG), .CasL(CasL), .CasE(CasE),
        .Busy(Busy), .Done(Done), .Gre(Gre), .Les(Les), .Equ(Equ)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    function automatic int model_lat(logic [15:0] a, logic [15:0] b);
        int lat;
        logic [15:0] d;
        lat = 4;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        d = a ^ b;
        for (int i = 3; i >= 0; i--)
            if (d[i*4 +: 4] != 4'h0) begin
                lat = 4 - i;
                break;
            end
`endif
        return lat;
    endfunction

    function automatic logic [2:0] model_res(logic [15:0] a, logic [15:0] b, logic s,
                                             logic cg, logic cl, logic ce);
        logic lt;
        if (a != b) begin
            lt = s ? ($signed(a) < $signed(b)) : (a < b);
            return lt ? 3'b010 : 3'b100;
        end
        if (cg) return 3'b100;
        if (cl) return 3'b010;
        if (ce) return 3'b001;
        return 3'b001;
    endfunction

    // Scoreboard: every Done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && Done) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: got Done=1 at edge %0d, required no Done", edges);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({Gre, Les, Equ} !== e.res || edges != e.at) begin
                    mismatched++;
                    $display("FAIL result: got GLE=%b at edge %0d, required GLE=%b at edge %0d",
                             {Gre, Les, Equ}, edges, e.res, e.at);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic cg, input logic cl, input logic ce);
        exp_t e;
        @(negedge clk);
        A = a; B = b; Signed = s; CasG = cg; CasL = cl; CasE = ce;
        Start = 1'b1;
        e.res = model_res(a, b, s, cg, cl, ce);
        e.at  = edges + 1 + model_lat(a, b);
        q.push_back(e);
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || Busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (q.size() != 0 || Busy) begin
            mismatched++;
            $display("FAIL timeout: got %0d pending results with Busy=%b, required 0 pending", q.size(), Busy);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({Busy, Done, Gre, Les, Equ} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_state: got BDGLE=%b, required 00000", {Busy, Done, Gre, Les, Equ});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        issue(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        issue(16'h5000, 16'h4FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            issue(16'($urandom), 16'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            wait_idle();
        end
    endtask

    task automatic test_signed();
        issue(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        issue(16'h7FF0, 16'h8F00, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle();
        issue(16'hF123, 16'hF124, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle();
    endtask

    task automatic test_cascade();
        issue(16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        issue(16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_idle();
        issue(16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        issue(16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_idle();
        issue(16'hABCD, 16'hABCE, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle();
    endtask

    // Start held high: accepts only when idle, including the Done cycle
    task automatic test_back_to_back();
        int free = 0;
        int e;
        exp_t x;
        @(negedge clk);
        A = 16'h8000; B = 16'h7FFF; Signed = 1'b1; CasG = 1'b0; CasL = 1'b0; CasE = 1'b0;
        Start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e = edges + 1;
            compared++;
            if (Busy !== (e < free)) begin
                mismatched++;
                $display("FAIL busy_b2b: got Busy=%b before edge %0d, required %b", Busy, e, (e < free));
            end
            if (e >= free) begin
                x.res = 3'b010;
                x.at  = e + model_lat(A, B);
                q.push_back(x);
                free = x.at + 1;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        compared++;
        if ({Busy, Done, Gre, Les, Equ} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_mid: got BDGLE=%b, required 00000", {Busy, Done, Gre, Les, Equ});
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        compared++;
        if ({Busy, Gre, Les, Equ} !== 4'b0) begin
            mismatched++;
            $display("FAIL after_reset: got BGLE=%b, required 0000", {Busy, Gre, Les, Equ});
        end
        issue(16'h3333, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
    endtask

    task automatic test_hold();
        issue(16'h9000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        for (int i = 0; i < 20; i++) begin
            A = 16'($urandom); B = 16'($urandom); Signed = 1'($urandom);
            CasG = 1'($urandom); CasL = 1'($urandom); CasE = 1'($urandom);
            @(negedge clk);
            compared++;
            if ({Gre, Les, Equ} !== 3'b100 || Done !== 1'b0) begin
                mismatched++;
                $display("FAIL hold: got GLE=%b Done=%b, required GLE=100 Done=0", {Gre, Les, Equ}, Done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_cascade();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
